// File: rtl/decode_ctrl_pkg.sv
// rtl/decode_ctrl_pkg.sv - shared types and constants for the decode hazard controller
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MULTI = 2'b01,
    FLUSH = 2'b10
  } ctrl_state_t;

  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_MULTI_LAT    = 4;

  // Bits needed for the shared counter, never less than one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// rtl/ctrl_down_counter.sv - loadable down counter with zero flag, saturating at zero
module ctrl_down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decode_hazard_controller.sv
// rtl/decode_hazard_controller.sv - stall/flush sequencing for the decode stage
module decode_hazard_controller
  import decode_ctrl_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MULTI_LAT    = DEF_MULTI_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic             UseRA1D,
  input  logic             UseRA2D,
  input  logic [REG_W-1:0] WA3E,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             MultiD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BusyE,
  output logic [1:0]       StateO
);

  localparam int CW = cnt_width(FLUSH_CYCLES, MULTI_LAT);
  localparam logic [CW-1:0] MULTI_LOAD = CW'(MULTI_LAT - 2);
  // The counter holds the FLUSH cycles still to come after the current one,
  // so the branch cycle plus the FLUSH window totals FLUSH_CYCLES.
  localparam logic [CW-1:0] FLUSH_LOAD  = CW'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);
  localparam bit            FLUSH_ENTER = (FLUSH_CYCLES >= 2);

  ctrl_state_t state, state_next;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_value;
  logic        lw_stall;

  assign lw_stall = MemtoRegE & RegWriteE &
                    ((UseRA1D & (RA1D == WA3E)) | (UseRA2D & (RA2D == WA3E)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    cnt_dec    = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    BusyE      = 1'b0;
    case (state)
      RUN: begin
        if (BranchTakenE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          if (FLUSH_ENTER) begin
            state_next = FLUSH;
            cnt_load   = 1'b1;
            cnt_value  = FLUSH_LOAD;
          end
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (MultiD) begin
          state_next = MULTI;
          cnt_load   = 1'b1;
          cnt_value  = MULTI_LOAD;
        end
      end
      MULTI: begin
        StallF = 1'b1;
        StallD = 1'b1;
        BusyE  = 1'b1;
        if (cnt_zero) state_next = RUN;
        else          cnt_dec    = 1'b1;
      end
      FLUSH: begin
        FlushD = 1'b1;
        if (BranchTakenE) begin
          FlushE    = 1'b1;
          cnt_load  = 1'b1;
          cnt_value = FLUSH_LOAD;
        end else if (cnt_zero) begin
          state_next = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  ctrl_down_counter #(.WIDTH(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  assign StateO = state;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// tb/tb_decode_hazard_controller.sv - scoreboard bench for decode_hazard_controller
module tb_decode_hazard_controller;

  localparam int FC = 2;
  localparam int ML = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] RA1D, RA2D, WA3E;
  logic       UseRA1D, UseRA2D, RegWriteE, MemtoRegE, BranchTakenE, MultiD;
  logic       StallF, StallD, FlushD, FlushE, BusyE;
  logic [1:0] StateO;

  always #5 clk = ~clk;

  decode_hazard_controller #(.REG_W(4), .FLUSH_CYCLES(FC), .MULTI_LAT(ML)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .UseRA1D      (UseRA1D),
    .UseRA2D      (UseRA2D),
    .WA3E         (WA3E),
    .RegWriteE    (RegWriteE),
    .MemtoRegE    (MemtoRegE),
    .BranchTakenE (BranchTakenE),
    .MultiD       (MultiD),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .BusyE        (BusyE),
    .StateO       (StateO)
  );

  typedef struct {
    logic [6:0] exp;
    string      name;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    multi_left = 0;
  int    flush_left = 0;

  function automatic logic [6:0] mk(input logic sf, input logic sd, input logic fd,
                                    input logic fe, input logic be, input logic [1:0] st);
    return {sf, sd, fd, fe, be, st};
  endfunction

  // Reference model: remaining stall / flush windows counted in whole cycles.
  task automatic issue(input string nm, input logic [3:0] a1, input logic [3:0] a2,
                       input logic u1, input logic u2, input logic [3:0] w,
                       input logic rw, input logic m2r, input logic br, input logic md,
                       input logic rs);
    logic  lw;
    item_t it;
    @(posedge clk);
    #1;
    RA1D = a1; RA2D = a2; UseRA1D = u1; UseRA2D = u2; WA3E = w;
    RegWriteE = rw; MemtoRegE = m2r; BranchTakenE = br; MultiD = md; rst_n = rs;
    lw = m2r && rw && ((u1 && a1 == w) || (u2 && a2 == w));
    if (!rs) begin
      it.exp = '0;
      multi_left = 0;
      flush_left = 0;
    end else if (multi_left > 0) begin
      it.exp = mk(1, 1, 0, 0, 1, 2'b01);
      multi_left--;
    end else if (flush_left > 0) begin
      it.exp = mk(0, 0, 1, br, 0, 2'b10);
      if (br) flush_left = FC - 1;
      else    flush_left--;
    end else if (br) begin
      it.exp = mk(0, 0, 1, 1, 0, 2'b00);
      flush_left = FC - 1;
    end else if (lw) begin
      it.exp = mk(1, 1, 0, 1, 0, 2'b00);
    end else begin
      it.exp = '0;
      if (md) multi_left = ML - 1;
    end
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic idle(input string nm, input logic rs);
    issue(nm, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, rs);
  endtask

  always @(negedge clk) begin
    item_t      it;
    logic [6:0] act;
    if (q.size() > 0) begin
      it  = q.pop_front();
      act = {StallF, StallD, FlushD, FlushE, BusyE, StateO};
      tests++;
      if (act !== it.exp) begin
        fails++;
        $display("FAIL %s: got {sf,sd,fd,fe,be,st}=%b expected %b at %0t",
                 it.name, act, it.exp, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    RA1D = 4'($urandom); RA2D = 4'($urandom); WA3E = 4'($urandom);
    UseRA1D = 1'b1; UseRA2D = 1'b1; RegWriteE = 1'b1; MemtoRegE = 1'b1;
    BranchTakenE = 1'b1; MultiD = 1'b1;
    repeat (3) @(posedge clk);

    idle("reset_release", 1'b1);
    idle("reset_idle", 1'b1);

    issue("loaduse_hit", 4'd0, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("loaduse_after", 1'b1);
    issue("loaduse_unused", 4'd0, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("loaduse_unused_after", 1'b1);

    issue("branch_issue", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) idle("branch_window", 1'b1);

    issue("multi_issue", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("multi_window", 1'b1);
    issue("multi_branch_ignored", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) idle("multi_tail", 1'b1);

    issue("simultaneous", 4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) idle("simultaneous_after", 1'b1);

    issue("flush_rebranch_a", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    issue("flush_rebranch_b", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) idle("flush_rebranch_after", 1'b1);

    issue("midreset_multi", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("midreset_multi_c1", 1'b1);
    idle("midreset_assert", 1'b0);
    idle("midreset_hold", 1'b0);
    repeat (3) idle("midreset_release", 1'b1);

    for (int i = 0; i < 400; i++) begin
      issue("random",
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'b1);
    end

    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
